// File: rtl/button_debounce.sv
// Per-button debounce and press classification: turns synchronized, inverting
// button levels into single-cycle press / release / long-press / repeat events.
module button_debounce #(
  parameter int unsigned NUM_BUTTONS       = 2,
  parameter int unsigned DEBOUNCE_CYCLES   = 500_000,
  parameter int unsigned LONG_PRESS_CYCLES = 50_000_000,
  parameter int unsigned REPEAT_CYCLES     = 10_000_000
) (
  input  logic                   clock,
  input  logic                   reset_s2_n,
  input  logic [NUM_BUTTONS-1:0] button_s2_n,
  output logic [NUM_BUTTONS-1:0] pressed,
  output logic [NUM_BUTTONS-1:0] released,
  output logic [NUM_BUTTONS-1:0] long_pressed,
  output logic [NUM_BUTTONS-1:0] repeat_pulse,
  output logic [NUM_BUTTONS-1:0] button_state
);

  localparam int unsigned MAX_DL     = (DEBOUNCE_CYCLES > LONG_PRESS_CYCLES) ?
                                       DEBOUNCE_CYCLES : LONG_PRESS_CYCLES;
  localparam int unsigned MAX_CYCLES = (MAX_DL > REPEAT_CYCLES) ? MAX_DL : REPEAT_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES) + 1;

  localparam logic [CNT_W-1:0] DEB_LIMIT  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] LONG_LIMIT = CNT_W'(LONG_PRESS_CYCLES);
  localparam logic [CNT_W-1:0] REP_LIMIT  = CNT_W'(REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    LONG_HELD,
    RELEASE_WAIT
  } state_t;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
    state_t           state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_inc;
    logic             button_up;
    logic             long_flag;
    logic             press_q, release_q, long_q, repeat_q, level_q;

    assign button_up = button_s2_n[i];
    assign count_inc = count + CNT_ONE;

    // Counter is cleared on every state change, so it can never run past
    // the largest limit and never wraps.
    // NOTE: all state and outputs here update with <= so every branch reads
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge reset_s2_n) begin
      if (!reset_s2_n) begin
        state     <= IDLE;
        count     <= '0;
        long_flag <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        repeat_q  <= 1'b0;
        level_q   <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        repeat_q  <= 1'b0;
        case (state)
          IDLE: begin
            if (!button_up) begin
              state <= PRESS_WAIT;
              count <= CNT_ONE;
            end
          end
          PRESS_WAIT: begin
            if (button_up) begin
              state <= IDLE;
              count <= '0;
            end else if (count_inc == DEB_LIMIT) begin
              state   <= HELD;
              count   <= '0;
              press_q <= 1'b1;
              level_q <= 1'b1;
            end else begin
              count <= count_inc;
            end
          end
          HELD: begin
            if (button_up) begin
              state <= RELEASE_WAIT;
              count <= CNT_ONE;
            end else if (count_inc == LONG_LIMIT) begin
              state     <= LONG_HELD;
              count     <= '0;
              long_q    <= 1'b1;
              long_flag <= 1'b1;
            end else begin
              count <= count_inc;
            end
          end
          LONG_HELD: begin
            if (button_up) begin
              state <= RELEASE_WAIT;
              count <= CNT_ONE;
            end else if (count_inc == REP_LIMIT) begin
              count    <= '0;
              repeat_q <= 1'b1;
            end else begin
              count <= count_inc;
            end
          end
          RELEASE_WAIT: begin
            // A bounce back to pushed restarts long-press / repeat timing.
            if (!button_up) begin
              state <= long_flag ? LONG_HELD : HELD;
              count <= '0;
            end else if (count_inc == DEB_LIMIT) begin
              state     <= IDLE;
              count     <= '0;
              release_q <= 1'b1;
              level_q   <= 1'b0;
              long_flag <= 1'b0;
            end else begin
              count <= count_inc;
            end
          end
          default: begin
            state <= IDLE;
            count <= '0;
          end
        endcase
      end
    end

    assign pressed[i]      = press_q;
    assign released[i]     = release_q;
    assign long_pressed[i] = long_q;
    assign repeat_pulse[i] = repeat_q;
    assign button_state[i] = level_q;
  end

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce: table-driven vectors plus hand-written
// long-press and asynchronous-reset sequences.
module tb_button_debounce;

  localparam int N = 2;
  localparam int D = 4;
  localparam int L = 20;
  localparam int R = 5;

  logic         clock = 1'b0;
  logic         reset_s2_n;
  logic [N-1:0] button_s2_n;
  logic [N-1:0] pressed, released, long_pressed, repeat_pulse, button_state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] btn;
    logic [1:0] p;
    logic [1:0] r;
    logic [1:0] l;
    logic [1:0] rp;
    logic [1:0] s;
  } vec_t;

  vec_t vecs[$];

  button_debounce #(
    .NUM_BUTTONS      (N),
    .DEBOUNCE_CYCLES  (D),
    .LONG_PRESS_CYCLES(L),
    .REPEAT_CYCLES    (R)
  ) dut (
    .clock       (clock),
    .reset_s2_n  (reset_s2_n),
    .button_s2_n (button_s2_n),
    .pressed     (pressed),
    .released    (released),
    .long_pressed(long_pressed),
    .repeat_pulse(repeat_pulse),
    .button_state(button_state)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [1:0] p, input logic [1:0] r,
                            input logic [1:0] l, input logic [1:0] rp, input logic [1:0] s);
    check({tag, ".pressed"},      pressed,      p);
    check({tag, ".released"},     released,     r);
    check({tag, ".long_pressed"}, long_pressed, l);
    check({tag, ".repeat"},       repeat_pulse, rp);
    check({tag, ".state"},        button_state, s);
  endtask

  task automatic add(input int n, input logic [1:0] btn, input logic [1:0] p,
                     input logic [1:0] r, input logic [1:0] l, input logic [1:0] rp,
                     input logic [1:0] s);
    vec_t v;
    v.btn = btn; v.p = p; v.r = r; v.l = l; v.rp = rp; v.s = s;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  // Drive one input sample, let one rising edge consume it, sample on the falling edge.
  task automatic tick(input logic [1:0] btn);
    button_s2_n = btn;
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    reset_s2_n  = 1'b0;
    button_s2_n = 2'b11;
    repeat (2) @(negedge clock);
    check_outs("reset", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    reset_s2_n = 1'b1;
    repeat (3) tick(2'b11);
    check_outs("idle", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

    // Press button 0, hold 10 samples; button 1 untouched.
    add(3, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(1, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
    add(6, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
    // Release with a 2-sample low bounce, then a clean release.
    add(2, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
    add(2, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
    add(3, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
    add(1, 2'b11, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    add(2, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    // Press bounce: low 3, high 1, low 3, high -> nothing.
    add(3, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(3, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(3, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    // Both buttons on the same edge, then both released together.
    add(3, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(1, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11);
    add(2, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11);
    add(3, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11);
    add(1, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00);
    add(2, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

    for (int i = 0; i < vecs.size(); i++) begin
      tick(vecs[i].btn);
      check_outs($sformatf("vec%0d", i), vecs[i].p, vecs[i].r, vecs[i].l, vecs[i].rp, vecs[i].s);
    end

    // Long press on button 1: long at +L after pressed, repeats every R after that.
    for (int j = 0; j < D - 1; j++) begin
      tick(2'b01);
      check_outs($sformatf("lp_wait%0d", j), 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    end
    tick(2'b01);
    check_outs("lp_press", 2'b10, 2'b00, 2'b00, 2'b00, 2'b10);
    for (int j = 1; j <= 40; j++) begin
      logic [1:0] exp_l, exp_rp;
      exp_l  = (j == L) ? 2'b10 : 2'b00;
      exp_rp = (j > L && ((j - L) % R) == 0) ? 2'b10 : 2'b00;
      tick(2'b01);
      check_outs($sformatf("lp_hold%0d", j), 2'b00, 2'b00, exp_l, exp_rp, 2'b10);
    end
    for (int j = 0; j < D - 1; j++) begin
      tick(2'b11);
      check_outs($sformatf("lp_rel%0d", j), 2'b00, 2'b00, 2'b00, 2'b00, 2'b10);
    end
    tick(2'b11);
    check_outs("lp_released", 2'b00, 2'b10, 2'b00, 2'b00, 2'b00);

    // Reset while button 0 is held: immediate clear, then a fresh press.
    for (int j = 0; j < D - 1; j++) tick(2'b10);
    tick(2'b10);
    check_outs("rst_press", 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
    repeat (2) tick(2'b10);
    check_outs("rst_held", 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
    #2 reset_s2_n = 1'b0;
    #1 check_outs("rst_async", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    @(negedge clock);
    check_outs("rst_during", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    reset_s2_n = 1'b1;
    for (int j = 0; j < D - 1; j++) begin
      tick(2'b10);
      check_outs($sformatf("rst_wait%0d", j), 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    end
    tick(2'b10);
    check_outs("rst_repress", 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
    for (int j = 0; j < D - 1; j++) tick(2'b11);
    tick(2'b11);
    check_outs("rst_release", 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
